// File: rtl/fsm_xy_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_xy_monitor
//  Description : Receive-side decoder for the 3-state {A,B,C} Mealy encoder.
//                Tracks the set of states the encoder could be in, recovers
//                the encoder input bit whenever the observed {x,y} fixes it,
//                and flags symbols no candidate state can produce (then
//                resynchronises to "any state").
//  Ports       : clk      - clock, all updates on posedge
//                rst      - synchronous active-high reset
//                v        - sample valid for x/y
//                x, y     - observed encoder outputs
//                dv       - decoded-sample valid (1 cycle after v)
//                di       - recovered i (meaningful when dv & dk)
//                dk       - i unambiguous for this sample
//                err      - one-cycle pulse: sample illegal for all candidates
//                lock     - candidate set holds exactly one state
//                st       - candidate set: bit0=A, bit1=B, bit2=C
//                err_cnt  - saturating count of err pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module fsm_xy_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v,
  input  logic             x,
  input  logic             y,
  output logic             dv,
  output logic             di,
  output logic             dk,
  output logic             err,
  output logic             lock,
  output logic [2:0]       st,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0]       c_XY_01  = 2'b01;
  localparam logic [1:0]       c_XY_10  = 2'b10;
  localparam logic [1:0]       c_XY_11  = 2'b11;
  localparam logic [2:0]       c_ST_A   = 3'b001;
  localparam logic [2:0]       c_ST_ALL = 3'b111;
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       r_st;
  logic             r_dv;
  logic             r_di;
  logic             r_dk;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;

  logic [1:0] w_xy;
  logic       w_is01;
  logic       w_is10;
  logic       w_is11;
  logic [2:0] w_st_n;
  logic       w_i0;
  logic       w_i1;
  logic       w_none;

  assign w_xy   = {x, y};
  assign w_is01 = (w_xy == c_XY_01);
  assign w_is10 = (w_xy == c_XY_10);
  assign w_is11 = (w_xy == c_XY_11);

  // Successor set: union of next(s,i) over every candidate s and every i
  // whose output matches the observed symbol.
  //   A: 01/i0->B, 11/i1->C   B: 10/i0->B, 10/i1->C   C: 10/i0->A, 01/i1->C
  assign w_st_n[0] = w_is10 & r_st[2];
  assign w_st_n[1] = (w_is01 & r_st[0]) | (w_is10 & r_st[1]);
  assign w_st_n[2] = (w_is11 & r_st[0]) | (w_is01 & r_st[2]) | (w_is10 & r_st[1]);

  // Which input-bit values could have produced the symbol.
  assign w_i0 = (w_is01 & r_st[0]) | (w_is10 & r_st[1]) | (w_is10 & r_st[2]);
  assign w_i1 = (w_is11 & r_st[0]) | (w_is01 & r_st[2]) | (w_is10 & r_st[1]);

  assign w_none = (w_st_n == 3'b000);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st      <= c_ST_A;
      r_dv      <= 1'b0;
      r_di      <= 1'b0;
      r_dk      <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (v) begin
      r_dv <= 1'b1;
      if (w_none) begin
        // Illegal for every candidate: restart from "could be anywhere".
        r_err <= 1'b1;
        r_dk  <= 1'b0;
        r_di  <= 1'b0;
        r_st  <= c_ST_ALL;
        if (r_err_cnt != c_CNT_MAX) begin
          r_err_cnt <= r_err_cnt + c_CNT_ONE;
        end
      end else begin
        r_err <= 1'b0;
        r_dk  <= w_i0 ^ w_i1;
        r_di  <= w_i1 & ~w_i0;
        r_st  <= w_st_n;
      end
    end else begin
      // Idle: di/dk keep the last decoded value, state and count hold.
      r_dv  <= 1'b0;
      r_err <= 1'b0;
    end
  end

  assign dv      = r_dv;
  assign di      = r_di;
  assign dk      = r_dk;
  assign err     = r_err;
  assign st      = r_st;
  assign err_cnt = r_err_cnt;
  assign lock    = (r_st == 3'b001) | (r_st == 3'b010) | (r_st == 3'b100);

endmodule
`default_nettype wire

// File: tb/tb_fsm_xy_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsm_xy_monitor
//  Description : Scoreboard bench for fsm_xy_monitor. A driver issues samples
//                and queues the expected response for the cycle it is due;
//                a monitor pops and compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_xy_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v   = 1'b0;
  logic       x   = 1'b0;
  logic       y   = 1'b0;
  logic       dv, di, dk, err, lock;
  logic [2:0] st;
  logic [7:0] err_cnt;
  logic       dv2, di2, dk2, err2, lock2;
  logic [2:0] st2;
  logic [1:0] err_cnt2;

  fsm_xy_monitor #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .v(v), .x(x), .y(y),
    .dv(dv), .di(di), .dk(dk), .err(err), .lock(lock), .st(st), .err_cnt(err_cnt)
  );

  fsm_xy_monitor #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .v(v), .x(x), .y(y),
    .dv(dv2), .di(di2), .dk(dk2), .err(err2), .lock(lock2), .st(st2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  // kind 0: directed (all fields), 1: random valid sample, 2: random idle
  typedef struct {
    int         kind;
    int         due;
    logic       dv, di, dk, err, lock;
    logic [2:0] st;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    int         ti;
    int         ts;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // Monitor: compare every expectation that falls due this cycle.
  always @(negedge clk) begin
    bit popped;
    exp_t e;
    popped = 1'b0;
    while (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      popped = 1'b1;
      case (e.kind)
        0: begin
          chk("dv", dv, e.dv);
          chk("di", di, e.di);
          chk("dk", dk, e.dk);
          chk("err", err, e.err);
          chk("lock", lock, e.lock);
          chk("st", st, e.st);
          chk("err_cnt", err_cnt, e.cnt);
          chk("err_cnt_w2", err_cnt2, e.cnt2);
        end
        1: begin
          chk("rnd_dv", dv, 1);
          chk("rnd_err", err, 0);
          if (dk) chk("rnd_di", di, e.ti);
          chk("rnd_true_state_in_st", st[e.ts], 1);
        end
        default: begin
          chk("idle_dv", dv, 0);
          chk("idle_err", err, 0);
        end
      endcase
    end
    if (dv && !popped) chk("unexpected_dv", dv, 0);
  end

  task automatic drive(input logic r, input logic vv, input logic [1:0] xy);
    @(posedge clk);
    #1;
    rst = r;
    v   = vv;
    {x, y} = xy;
  endtask

  task automatic dir(input logic r, input logic vv, input logic [1:0] xy,
                     input logic edv, input logic edi, input logic edk,
                     input logic eerr, input logic elock, input logic [2:0] est,
                     input logic [7:0] ec, input logic [1:0] ec2);
    exp_t e;
    drive(r, vv, xy);
    e.kind = 0; e.due = cyc + 1;
    e.dv = edv; e.di = edi; e.dk = edk; e.err = eerr; e.lock = elock;
    e.st = est; e.cnt = ec; e.cnt2 = ec2; e.ti = 0; e.ts = 0;
    q.push_back(e);
  endtask

  initial begin
    int   enc;
    int   i;
    int   nxt;
    logic [1:0] xy;
    exp_t e;

    //   r  v  xy     dv di dk er lk st      cnt cnt2
    // Reset state
    dir(1, 0, 2'b00, 0, 0, 0, 0, 1, 3'b001, 0, 0);
    // Locked decode: 11,10,01 from A
    dir(0, 1, 2'b11, 1, 1, 1, 0, 1, 3'b100, 0, 0);
    dir(0, 1, 2'b10, 1, 0, 1, 0, 1, 3'b001, 0, 0);
    dir(0, 1, 2'b01, 1, 0, 1, 0, 1, 3'b010, 0, 0);
    // Ambiguous from B, then resolved by 01
    dir(0, 1, 2'b10, 1, 0, 0, 0, 0, 3'b110, 0, 0);
    dir(0, 1, 2'b01, 1, 1, 1, 0, 1, 3'b100, 0, 0);
    // Go to A, then illegal 10 from A, then recover with 11
    dir(0, 1, 2'b10, 1, 0, 1, 0, 1, 3'b001, 0, 0);
    dir(0, 1, 2'b10, 1, 0, 0, 1, 0, 3'b111, 1, 1);
    dir(0, 1, 2'b11, 1, 1, 1, 0, 1, 3'b100, 1, 1);
    // v toggling 1,0,0,1: idle cycles hold st/di/dk
    dir(0, 1, 2'b01, 1, 1, 1, 0, 1, 3'b100, 1, 1);
    dir(0, 0, 2'b10, 0, 1, 1, 0, 1, 3'b100, 1, 1);
    dir(0, 0, 2'b00, 0, 1, 1, 0, 1, 3'b100, 1, 1);
    dir(0, 1, 2'b10, 1, 0, 1, 0, 1, 3'b001, 1, 1);
    // Fresh reset, then five illegal 00 samples: saturation in the 2-bit counter
    dir(1, 0, 2'b00, 0, 0, 0, 0, 1, 3'b001, 0, 0);
    dir(0, 1, 2'b00, 1, 0, 0, 1, 0, 3'b111, 1, 1);
    dir(0, 1, 2'b00, 1, 0, 0, 1, 0, 3'b111, 2, 2);
    dir(0, 1, 2'b00, 1, 0, 0, 1, 0, 3'b111, 3, 3);
    dir(0, 1, 2'b00, 1, 0, 0, 1, 0, 3'b111, 4, 3);
    dir(0, 1, 2'b00, 1, 0, 0, 1, 0, 3'b111, 5, 3);
    // From all-states, 11 can only come from A
    dir(0, 1, 2'b11, 1, 1, 1, 0, 1, 3'b100, 5, 3);
    // Reset mid-stream with v=1 wins
    dir(1, 1, 2'b01, 0, 0, 0, 0, 1, 3'b001, 0, 0);

    // Random encoder stream from state A, with occasional idle cycles
    enc = 0;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        drive(0, 0, 2'($urandom_range(0, 3)));
        e.kind = 2; e.due = cyc + 1; e.ti = 0; e.ts = 0;
        q.push_back(e);
      end else begin
        i = int'($urandom_range(0, 1));
        case (enc)
          0:       begin xy = (i == 0) ? 2'b01 : 2'b11; nxt = (i == 0) ? 1 : 2; end
          1:       begin xy = 2'b10;                    nxt = (i == 0) ? 1 : 2; end
          default: begin xy = (i == 0) ? 2'b10 : 2'b01; nxt = (i == 0) ? 0 : 2; end
        endcase
        drive(0, 1, xy);
        e.kind = 1; e.due = cyc + 1; e.ti = i; e.ts = nxt;
        q.push_back(e);
        enc = nxt;
      end
    end
    drive(0, 0, 2'b00);

    for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) chk("scoreboard_drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
